mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 5, memory address width; DWIDTH, default 8, memory data width.
REQ-002 Ports SHALL be: clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  CPU access request (rd|wr from controller).
REQ-005 cpu_wr  in  1  CPU write when high, read when low.
REQ-006 cpu_addr  in  AWIDTH  CPU address.
REQ-007 cpu_wdata  in  DWIDTH  CPU write data.
REQ-008 cpu_halt  in  1  CPU halted.
REQ-009 cpu_stall  out  1  freeze CPU phase counter this cycle.
REQ-010 cpu_rdata  out  DWIDTH  CPU read data, mem_rdata passthrough.
REQ-011 host_req / host_wr / host_lock  in  1 each  host request, write, and burst-lock hold.
REQ-012 host_addr  in  AWIDTH;  host_wdata  in  DWIDTH  host address and write data.
REQ-013 host_gnt  out  1  host access performed this cycle.
REQ-014 host_done  out  1  one-cycle pulse the cycle after any host grant.
REQ-015 host_rdata  out  DWIDTH  registered host read data.
REQ-016 mem_rd / mem_wr  out  1 each;  mem_addr  out  AWIDTH;  mem_wdata  out  DWIDTH  memory port.
REQ-017 mem_rdata  in  DWIDTH  memory read data, valid the cycle after mem_rd.
REQ-018 stat_conflicts  out  16  contention counter.

Function
REQ-019 FSM SHALL have states ARB and LOCK.
REQ-020 Winner decision in ARB SHALL be combinational from requests and the registered last_owner bit.
- Only one requester: it wins.
- Both: the one not equal to last_owner wins.
- cpu_halt=1: host always wins.
REQ-021 In LOCK the host SHALL be sole owner; cpu_stall=cpu_req; a host grant occurs each cycle host_req=1.
REQ-022 ARB->LOCK SHALL occur on the edge ending a host grant with host_lock=1; LOCK->ARB on the first edge with host_lock=0.
REQ-023 Memory outputs SHALL be the winner's signals, mem_rd=req&~wr, mem_wr=req&wr; no winner -> mem_rd=mem_wr=0, address/data 0.
REQ-024 cpu_stall SHALL equal cpu_req & ~cpu_wins; host_gnt SHALL equal host_wins; both combinational, zero latency.
REQ-025 last_owner SHALL update to the winner on each granted cycle and hold otherwise.
REQ-026 On the edge after a host read grant, host_rdata SHALL load mem_rdata; after a host write grant it SHALL hold; host_done SHALL be high exactly one cycle after every host grant.
REQ-027 stat_conflicts SHALL increment on each cycle with cpu_req&host_req in ARB and saturate at 16'hFFFF.
REQ-028 Back-to-back grants SHALL be allowed; no idle cycle is required between owners.

Reset
REQ-029 rst SHALL force, asynchronously: state=ARB, last_owner=HOST (CPU wins the first tie), host_rdata=0, host_done=0, stat_conflicts=0.
REQ-030 Reset during LOCK or a pending host_done SHALL abort it; no host_done pulse follows reset.

Configuration
REQ-031 Macro ARB_STATS_EN defined: the stat_conflicts counter SHALL be built as specified.
REQ-032 ARB_STATS_EN undefined: stat_conflicts SHALL be tied to 0, no counter flops.

Structure
REQ-033 Shared package mem_arb_pkg SHALL hold the FSM state typedef, the owner encoding (OWN_CPU=0, OWN_HOST=1), and the counter width constant 16.
REQ-034 Sub-module arb_sat_counter (saturating counter) SHALL be the single sub-module, instantiated only under ARB_STATS_EN.

Verification
REQ-035 Bench SHALL cover the following directed scenarios:
- CPU read alone, addr 5'h03: mem_rd=1, mem_addr=3, cpu_stall=0; next cycle cpu_rdata=mem_rdata.
- Tie after reset, both request 3 cycles: winners CPU, HOST, CPU; cpu_stall=1 only in cycle 2; stat_conflicts=3.
- Host read addr 5'h1F with mem_rdata=8'hA5: host_gnt that cycle; next cycle host_done=1, host_rdata=8'hA5.
- host_lock=1 across 4 host writes with cpu_req=1: cpu_stall=1 for all 4 cycles plus the transition; ARB after host_lock=0.
- cpu_halt=1 with both requesting: host wins every cycle.
- rst asserted mid-LOCK: state ARB, host_done=0, counters 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the CPU/host memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam int c_STAT_WIDTH = 16;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : arb_sat_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-way CPU/host arbiter for a single-port memory, with host
//            burst lock and optional contention counter (macro ARB_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic              cpu_halt,
    output logic              cpu_stall,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic              host_lock,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_done,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [15:0]       stat_conflicts
);

    arb_state_t        r_state;
    logic              r_last_owner;
    logic              r_host_done;
    logic [DWIDTH-1:0] r_host_rdata;

    logic w_cpu_wins;
    logic w_host_wins;

    // Ties go to whoever did not own the memory last; a halted CPU always yields.
    always_comb begin
        w_cpu_wins  = 1'b0;
        w_host_wins = 1'b0;
        if (r_state == ST_LOCK) begin
            w_host_wins = host_req;
        end else if (cpu_req && host_req) begin
            if (cpu_halt || (r_last_owner == OWN_CPU)) begin
                w_host_wins = 1'b1;
            end else begin
                w_cpu_wins = 1'b1;
            end
        end else begin
            w_cpu_wins  = cpu_req;
            w_host_wins = host_req;
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_wins) begin
            mem_rd    = ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_host_wins) begin
            mem_rd    = ~host_wr;
            mem_wr    = host_wr;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_last_owner <= OWN_HOST;
            r_host_done  <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_host_done <= w_host_wins;
            if (w_host_wins && !host_wr) begin
                r_host_rdata <= mem_rdata;
            end
            if (w_cpu_wins) begin
                r_last_owner <= OWN_CPU;
            end else if (w_host_wins) begin
                r_last_owner <= OWN_HOST;
            end
            case (r_state)
                ST_ARB: begin
                    if (w_host_wins && host_lock) begin
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (!host_lock) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign cpu_stall  = cpu_req & ~w_cpu_wins;
    assign host_gnt   = w_host_wins;
    assign host_done  = r_host_done;
    assign host_rdata = r_host_rdata;
    assign cpu_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
    logic w_conflict;
    assign w_conflict = (r_state == ST_ARB) & cpu_req & host_req;

    arb_sat_counter #(
        .WIDTH (c_STAT_WIDTH)
    ) u_stat_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_conflict),
        .o_count (stat_conflicts)
    );
`else
    assign stat_conflicts = '0;
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scoreboard bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
`ifdef ARB_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wr, cpu_halt, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          host_req, host_wr, host_lock, host_gnt, host_done;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   stat_conflicts;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_wr         (cpu_wr),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_halt       (cpu_halt),
        .cpu_stall      (cpu_stall),
        .cpu_rdata      (cpu_rdata),
        .host_req       (host_req),
        .host_wr        (host_wr),
        .host_lock      (host_lock),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .host_done      (host_done),
        .host_rdata     (host_rdata),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .stat_conflicts (stat_conflicts)
    );

    typedef struct {
        logic          done;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_rdata;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_halt = 0;
        host_req = 0; host_wr = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        sb_q.delete();
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst.done",  32'(host_done),      32'h0);
        check_val("rst.rdata", 32'(host_rdata),     32'h0);
        check_val("rst.stat",  32'(stat_conflicts), 32'h0);
    endtask

    // One clock of stimulus; ecw/ehw are the winners this cycle should produce.
    task automatic step(input string tag,
                        input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic halt,
                        input logic hr, input logic hw, input logic hl, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd, input logic [DW-1:0] mrd,
                        input logic ecw, input logic ehw);
        exp_t          e;
        exp_t          o;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        logic          erd, ewr;
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd; cpu_halt = halt;
        host_req = hr; host_wr = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
        mem_rdata = mrd;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            o = sb_q.pop_front();
            check_val({tag, ".done"},  32'(host_done),  32'(o.done));
            check_val({tag, ".hrdat"}, 32'(host_rdata), 32'(o.rdata));
        end
        eaddr = ecw ? ca : (ehw ? ha : '0);
        ewd   = ecw ? cd : (ehw ? hd : '0);
        erd   = ecw ? ~cw : (ehw ? ~hw : 1'b0);
        ewr   = ecw ? cw : (ehw ? hw : 1'b0);
        check_val({tag, ".gnt"},   32'(host_gnt),  32'(ehw));
        check_val({tag, ".stall"}, 32'(cpu_stall), 32'(cr & ~ecw));
        check_val({tag, ".mrd"},   32'(mem_rd),    32'(erd));
        check_val({tag, ".mwr"},   32'(mem_wr),    32'(ewr));
        check_val({tag, ".addr"},  32'(mem_addr),  32'(eaddr));
        check_val({tag, ".wdat"},  32'(mem_wdata), 32'(ewd));
        check_val({tag, ".crdat"}, 32'(cpu_rdata), 32'(mrd));
        if (ehw && !hw) exp_rdata = mrd;
        e.done  = ehw;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t o;

        // CPU read alone
        apply_reset();
        step("cpu_rd",   1, 0, 5'h03, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h3C, 1, 0);
        step("cpu_rd2",  0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h3C, 0, 0);

        // Tie after reset: CPU, HOST, CPU
        apply_reset();
        step("tie1", 1, 1, 5'h01, 8'h11, 0, 1, 0, 0, 5'h02, 8'h22, 8'h61, 1, 0);
        step("tie2", 1, 1, 5'h01, 8'h11, 0, 1, 0, 0, 5'h02, 8'h22, 8'h62, 0, 1);
        step("tie3", 1, 1, 5'h01, 8'h11, 0, 1, 0, 0, 5'h02, 8'h22, 8'h63, 1, 0);
        step("tie_idle", 0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 0);
        check_val("tie.stat", 32'(stat_conflicts), c_STATS ? 32'd3 : 32'd0);

        // Host read at top address
        apply_reset();
        step("h_rd",  0, 0, 5'h00, 8'h00, 0, 1, 0, 0, 5'h1F, 8'h00, 8'hA5, 0, 1);
        step("h_rd2", 0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'hA5, 0, 0);

        // Host burst lock across 4 writes while CPU keeps requesting
        apply_reset();
        step("lk_pre", 1, 0, 5'h04, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("lk_w%0d", i), 1, 0, 5'h01, 8'h00, 0, 1, 1, 1,
                 AW'(5'h08 + i), DW'(8'h10 + i), 8'h77, 0, 1);
        end
        step("lk_rel", 1, 0, 5'h01, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 0);
        step("lk_arb", 1, 1, 5'h06, 8'h5C, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 1, 0);
        check_val("lk.stat", 32'(stat_conflicts), c_STATS ? 32'd1 : 32'd0);

        // Halted CPU: host wins even the first tie
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step($sformatf("halt%0d", i), 1, 0, 5'h02, 8'h00, 1, 1, 0, 0,
                 AW'(5'h10 + i), 8'h00, DW'(8'hC0 + i), 0, 1);
        end
        step("halt_idle", 0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 0);
        check_val("halt.stat", 32'(stat_conflicts), c_STATS ? 32'd3 : 32'd0);

        // Reset in the middle of a lock with a host_done pending
        apply_reset();
        step("rl_pre",  1, 0, 5'h04, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 1, 0);
        step("rl_ent",  1, 0, 5'h04, 8'h00, 0, 1, 1, 1, 5'h09, 8'h99, 8'h00, 0, 1);
        step("rl_rd",   1, 0, 5'h04, 8'h00, 0, 1, 0, 1, 5'h07, 8'h00, 8'h5A, 0, 1);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check_val("rl.done_pend", 32'(host_done),  32'(o.done));
        check_val("rl.rdat_pend", 32'(host_rdata), 32'(o.rdata));
        rst = 1'b1;
        #1;
        check_val("rl.async_done",  32'(host_done),      32'h0);
        check_val("rl.async_rdata", 32'(host_rdata),     32'h0);
        check_val("rl.async_stat",  32'(stat_conflicts), 32'h0);
        sb_q.delete();
        exp_rdata = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        step("rl_post", 1, 0, 5'h05, 8'h00, 0, 0, 0, 1, 5'h00, 8'h00, 8'h00, 1, 0);
        step("rl_idle", 0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
